// File: rtl/pipe_reg_de.sv
// D->E pipeline register: captures decoded context, turns a stall into a nop bubble, and supports a full freeze.
// Optional bubble counter is built only when PIPE_REG_DE_BUBBLE_CNT_EN is defined; otherwise bubble_cnt is tied to 0.
module pipe_reg_de #(
   parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] D_instr,
   input  logic [31:0] D_pc,
   input  logic [31:0] D_rs_data,
   input  logic [31:0] D_rt_data,
   input  logic [31:0] D_imm32,
   input  logic        stall,
   input  logic        freeze,
   output logic [31:0] E_instr,
   output logic [31:0] E_pc,
   output logic [31:0] E_pc8,
   output logic [31:0] E_rs_data,
   output logic [31:0] E_rt_data,
   output logic [31:0] E_imm32,
   output logic [4:0]  E_rs,
   output logic [4:0]  E_rt,
   output logic        E_valid,
   output logic [31:0] bubble_cnt
);

   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] rs_data_q, rs_data_d;
   logic [31:0] rt_data_q, rt_data_d;
   logic [31:0] imm32_q, imm32_d;
   logic        valid_q, valid_d;

   always_comb begin
      instr_d   = instr_q;
      pc_d      = pc_q;
      rs_data_d = rs_data_q;
      rt_data_d = rt_data_q;
      imm32_d   = imm32_q;
      valid_d   = valid_q;
      if (freeze) begin
         // hold everything
      end else if (stall) begin
         // all-zero word is sll $0,$0,0; PC still follows D so the trail stays continuous
         instr_d   = 32'h0;
         pc_d      = D_pc;
         rs_data_d = 32'h0;
         rt_data_d = 32'h0;
         imm32_d   = 32'h0;
         valid_d   = 1'b0;
      end else begin
         instr_d   = D_instr;
         pc_d      = D_pc;
         rs_data_d = D_rs_data;
         rt_data_d = D_rt_data;
         imm32_d   = D_imm32;
         valid_d   = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instr_q   <= 32'h0;
         pc_q      <= PC_RESET;
         rs_data_q <= 32'h0;
         rt_data_q <= 32'h0;
         imm32_q   <= 32'h0;
         valid_q   <= 1'b0;
      end else begin
         instr_q   <= instr_d;
         pc_q      <= pc_d;
         rs_data_q <= rs_data_d;
         rt_data_q <= rt_data_d;
         imm32_q   <= imm32_d;
         valid_q   <= valid_d;
      end
   end

`ifdef PIPE_REG_DE_BUBBLE_CNT_EN
   logic [31:0] bubble_cnt_q, bubble_cnt_d;

   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      if (!freeze && stall) begin
         bubble_cnt_d = bubble_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bubble_cnt_q <= 32'h0;
      end else begin
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign bubble_cnt = bubble_cnt_q;
`else
   assign bubble_cnt = 32'h0;
`endif

   assign E_instr   = instr_q;
   assign E_pc      = pc_q;
   assign E_pc8     = pc_q + 32'd8;
   assign E_rs_data = rs_data_q;
   assign E_rt_data = rt_data_q;
   assign E_imm32   = imm32_q;
   assign E_rs      = instr_q[25:21];
   assign E_rt      = instr_q[20:16];
   assign E_valid   = valid_q;

endmodule

// File: tb/tb_pipe_reg_de.sv
// Self-checking bench for pipe_reg_de: a per-edge behavioural model checked every negedge, plus literal spot checks.
module tb_pipe_reg_de;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] D_instr = '0, D_pc = '0, D_rs_data = '0, D_rt_data = '0, D_imm32 = '0;
   logic        stall = 1'b0, freeze = 1'b0;
   logic [31:0] E_instr, E_pc, E_pc8, E_rs_data, E_rt_data, E_imm32, bubble_cnt;
   logic [4:0]  E_rs, E_rt;
   logic        E_valid;

   pipe_reg_de dut (
      .clk(clk), .reset(reset),
      .D_instr(D_instr), .D_pc(D_pc), .D_rs_data(D_rs_data), .D_rt_data(D_rt_data), .D_imm32(D_imm32),
      .stall(stall), .freeze(freeze),
      .E_instr(E_instr), .E_pc(E_pc), .E_pc8(E_pc8), .E_rs_data(E_rs_data), .E_rt_data(E_rt_data),
      .E_imm32(E_imm32), .E_rs(E_rs), .E_rt(E_rt), .E_valid(E_valid), .bubble_cnt(bubble_cnt)
   );

   always #5 clk = ~clk;

   // model of the E-stage contents
   logic [31:0] m_instr, m_pc, m_rs, m_rt, m_imm, m_cnt;
   logic        m_valid;
   int          n_pass = 0, n_total = 0;
   bit          cmp_en = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h at t=%0t", name, act, exp, $time);
   endtask

   function automatic logic [31:0] exp_cnt();
`ifdef PIPE_REG_DE_BUBBLE_CNT_EN
      return m_cnt;
`else
      return 32'h0;
`endif
   endfunction

   task automatic model_reset();
      m_instr = 0; m_pc = 32'h0000_3000; m_rs = 0; m_rt = 0; m_imm = 0; m_valid = 0; m_cnt = 0;
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("E_instr", E_instr, m_instr);
         chk("E_pc", E_pc, m_pc);
         chk("E_pc8", E_pc8, m_pc + 32'd8);
         chk("E_rs_data", E_rs_data, m_rs);
         chk("E_rt_data", E_rt_data, m_rt);
         chk("E_imm32", E_imm32, m_imm);
         chk("E_rs", {27'b0, E_rs}, {27'b0, m_instr[25:21]});
         chk("E_rt", {27'b0, E_rt}, {27'b0, m_instr[20:16]});
         chk("E_valid", {31'b0, E_valid}, {31'b0, m_valid});
         chk("bubble_cnt", bubble_cnt, exp_cnt());
      end
   end

   // apply inputs, advance one rising edge, update model, return at edge+1
   task automatic step(input logic st, input logic fr, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm);
      stall = st; freeze = fr;
      D_instr = ins; D_pc = pc; D_rs_data = rs; D_rt_data = rt; D_imm32 = imm;
      @(posedge clk);
      if (!reset) begin
         if (fr) begin
         end else if (st) begin
            m_instr = 0; m_pc = pc; m_rs = 0; m_rt = 0; m_imm = 0; m_valid = 0; m_cnt = m_cnt + 1;
         end else begin
            m_instr = ins; m_pc = pc; m_rs = rs; m_rt = rt; m_imm = imm; m_valid = 1;
         end
      end
      $display("step st=%0b fr=%0b instr=%08h pc=%08h -> E_instr=%08h E_pc=%08h E_valid=%0b cnt=%0d",
               st, fr, ins, pc, m_instr, m_pc, m_valid, m_cnt);
      #1;
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin
      #1 reset = 1'b1;
      model_reset();
      cmp_en = 1;
      release_reset();

      // load add $8,$17,$18
      step(0, 0, 32'h0232_4020, 32'h0000_3004, 32'd5, 32'd7, 32'h0000_0020);
      chk("lit_load_instr", E_instr, 32'h0232_4020);
      chk("lit_load_rs", {27'b0, E_rs}, 32'd17);
      chk("lit_load_rt", {27'b0, E_rt}, 32'd18);
      chk("lit_load_rsd", E_rs_data, 32'd5);
      chk("lit_load_rtd", E_rt_data, 32'd7);
      chk("lit_load_pc8", E_pc8, 32'h0000_300C);
      chk("lit_load_valid", {31'b0, E_valid}, 32'd1);

      // two stall edges
      for (int i = 0; i < 2; i++) begin
         step(1, 0, 32'h1234_5678, 32'h0000_3010, 32'd9, 32'd9, 32'd9);
         chk("lit_stall_instr", E_instr, 32'h0);
         chk("lit_stall_valid", {31'b0, E_valid}, 32'd0);
         chk("lit_stall_pc", E_pc, 32'h0000_3010);
      end
`ifdef PIPE_REG_DE_BUBBLE_CNT_EN
      chk("lit_stall_cnt", bubble_cnt, 32'd2);
`else
      chk("lit_stall_cnt", bubble_cnt, 32'd0);
`endif

      // freeze beats stall
      step(1, 1, 32'hDEAD_BEEF, 32'h0000_4000, 32'd1, 32'd2, 32'd3);
      chk("lit_frz_pc", E_pc, 32'h0000_3010);
      chk("lit_frz_instr", E_instr, 32'h0);
      chk("lit_frz_rsd", E_rs_data, 32'h0);
`ifdef PIPE_REG_DE_BUBBLE_CNT_EN
      chk("lit_frz_cnt", bubble_cnt, 32'd2);
`else
      chk("lit_frz_cnt", bubble_cnt, 32'd0);
`endif

      // load all-ones, then reset mid-cycle
      step(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      #2 reset = 1'b1;
      model_reset();
      #1;
      chk("lit_rst_instr", E_instr, 32'h0);
      chk("lit_rst_valid", {31'b0, E_valid}, 32'd0);
      chk("lit_rst_pc", E_pc, 32'h0000_3000);
      chk("lit_rst_pc8", E_pc8, 32'h0000_3008);
      chk("lit_rst_cnt", bubble_cnt, 32'd0);
      release_reset();

      // E_valid marks origin: a zero word loaded is still valid
      step(0, 0, 32'h0, 32'h0000_3020, 32'd0, 32'd0, 32'd0);
      chk("lit_zero_valid", {31'b0, E_valid}, 32'd1);

      // reset while stalling
      step(1, 0, 32'h0, 32'h0000_3024, 32'd0, 32'd0, 32'd0);
      stall = 1'b1;
      #2 reset = 1'b1;
      model_reset();
      #1;
      chk("lit_rststall_pc", E_pc, 32'h0000_3000);
      chk("lit_rststall_valid", {31'b0, E_valid}, 32'd0);
      release_reset();
      step(0, 0, 32'h8C88_0004, 32'h0000_3028, 32'd11, 32'd12, 32'd4);
      chk("lit_postrst_valid", {31'b0, E_valid}, 32'd1);
      chk("lit_postrst_instr", E_instr, 32'h8C88_0004);

      // PC wrap on the link value
      step(0, 0, 32'h0C00_0000, 32'hFFFF_FFFC, 32'd1, 32'd2, 32'd3);
      chk("lit_wrap_pc8", E_pc8, 32'h0000_0004);

      // stall glitch between edges has no effect
      stall = 1'b1;
      #2 stall = 1'b0;
      step(0, 0, 32'h2008_0001, 32'h0000_3030, 32'd6, 32'd7, 32'd1);
      chk("lit_glitch_valid", {31'b0, E_valid}, 32'd1);

      // mixed sequence against the model
      for (int i = 0; i < 60; i++) begin
         step(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), $urandom, $urandom,
              $urandom, $urandom, $urandom);
      end

      @(negedge clk);
      #1;
      cmp_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
